uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Parametrised single-clock UART transmit engine, the successor to the fixed 8N1 transmitter.
- Frame format is configurable: data width, optional parity, odd/even parity, 1 or 2 stop bits, oversample ratio.
- Takes bytes over a valid/ready handshake instead of an internal FIFO. A FIFO, if needed, sits upstream.
- Supports back-to-back frames with no idle gap, plus a line-break mode.
- Sits between the TX FIFO read side and the pad, in the transmit clock domain.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
OVERSAMPLE, 16, clk_tf cycles per bit; legal 2..256.
PARITY_EN, 0, 1 = insert parity bit after the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
clk_tf  input  1  transmit clock
rst_n_tf  input  1  asynchronous active-low reset
tx_valid  input  1  upstream has a word on tx_data
tx_data  input  DATA_W  word to send, LSB transmitted first
tx_ready  output  1  engine accepts tx_data this cycle
tx_break  input  1  request line break (hold line low)
transmitter_tx  output  1  serial line, idle high
tx_busy  output  1  frame or break in progress
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset values: transmitter_tx=1, tx_ready=0, tx_busy=0, tx_done=0. State=IDLE; bit counter, cycle counter and shift register all 0.
- All outputs are registered except tx_ready, which is combinational from state and counters.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Cycle counter: $clog2(OVERSAMPLE) bits. It counts 0..OVERSAMPLE-1 in every non-IDLE/non-BREAK state, then wraps to 0 at each bit boundary.
- tx_ready = !tx_break && (state==IDLE || (state==STOP && last stop bit && counter==OVERSAMPLE-1)).
- Accept: tx_valid && tx_ready at edge N.
  - Latch tx_data into the shift register.
  - Compute parity as XOR-reduce(tx_data) ^ PARITY_ODD.
  - Enter START. transmitter_tx=0 from cycle N+1.
- START: line 0 for OVERSAMPLE cycles, then DATA.
- DATA: DATA_W bits, LSB first, each held OVERSAMPLE cycles. Shift right at each bit boundary.
  - After the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: line = latched parity bit for OVERSAMPLE cycles, then STOP.
- STOP: line 1 for STOP_BITS*OVERSAMPLE cycles.
  - On the final cycle, tx_done=1 in the following cycle (registered pulse).
  - If accept also occurs on that final cycle, go directly to START: zero idle cycles between frames.
  - Otherwise go to IDLE.
- Frame length: OVERSAMPLE*(1+DATA_W+PARITY_EN+STOP_BITS) cycles from the first low cycle to the last stop cycle.
- tx_busy=1 in every state except IDLE.
- Break handling:
  - tx_break is sampled only in IDLE. If high, enter BREAK: line 0, tx_ready=0.
  - Stay in BREAK while tx_break=1. On deassert, go to IDLE with line 1 the next cycle.
  - tx_break asserted mid-frame is ignored until the frame completes. tx_break then takes priority over a pending tx_valid.
- Simultaneous tx_valid and tx_break in IDLE: break wins and the word is not accepted (tx_ready=0).
- tx_data is not sampled after accept; upstream may change it freely.
- Reset mid-frame: line returns high asynchronously. The partial frame is abandoned and no tx_done is produced.
- Elaboration: illegal parameter values trigger $error (generate-time check).

Decomposition:
- Package uart_pkg: state encoding localparams, parity helper function, legal-range constants for DATA_W/STOP_BITS.
- One sub-module, uart_bit_timer: an OVERSAMPLE-cycle counter with clear and a bit_end pulse. It is reusable by a future receiver.

Test Plan:
- 8N1, OVERSAMPLE=16, send 8'hA5 -> line low 16 cycles starting 1 cycle after accept. Then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_done pulse at cycle 160. tx_busy high 160 cycles.
- DATA_W=7, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 7'h53 -> bits 1,1,0,0,1,0,1, parity 0, two stop bits. Frame 176 cycles.
  - Rerun with PARITY_ODD=1 -> parity bit 1.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF -> second start bit begins the cycle after the first frame's last stop cycle, with no idle-high gap. Two tx_done pulses 160 cycles apart.
- Break: assert tx_break mid-frame -> frame completes unchanged. Then line low until tx_break drops, then high the next cycle. tx_ready stays 0 throughout.
- Reset: assert rst_n_tf=0 during DATA bit 3 -> transmitter_tx=1 immediately and no tx_done. After release, a new accept sends a clean frame.
- OVERSAMPLE=2, DATA_W=5 corner -> frame length 2*(1+5+1)=14 cycles. Counter wraps correctly at every bit boundary.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit engine and its bit timer:
//   - uart_state_e : frame FSM state encoding
//   - legal parameter ranges for DATA_W, STOP_BITS and OVERSAMPLE
//   - BIT_CNT_W    : width of the per-frame bit counter (data bits / stop bits)
//   - parity_bit() : parity over a zero-extended data word
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int DATA_W_MIN     = 5;
  localparam int DATA_W_MAX     = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;
  localparam int OVERSAMPLE_MIN = 2;
  localparam int OVERSAMPLE_MAX = 256;

  // Counts up to DATA_W_MAX-1 data bits or STOP_BITS_MAX-1 stop bits.
  localparam int BIT_CNT_W = 4;

  // Zero-extension does not change the XOR reduction, so narrower words can
  // be passed in widened to DATA_W_MAX.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running OVERSAMPLE-cycle counter used to time one serial bit. Held at
// zero while clear is high; otherwise counts 0..OVERSAMPLE-1 and wraps.
// Shared between the transmitter and a future receiver.
//
// Ports:
//   clk_tf    in   transmit clock
//   rst_n_tf  in   asynchronous active-low reset
//   clear     in   hold the counter at 0 (no bit in progress)
//   bit_end   out  high on the last cycle of a bit (combinational)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_tf,
  input  logic rst_n_tf,
  input  logic clear,
  output logic bit_end
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = !clear && (count == LAST_CNT);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk_tf or negedge rst_n_tf) begin
    if (!rst_n_tf) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmit engine: start bit, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits, each bit OVERSAMPLE clk_tf cycles long.
// Words arrive over a valid/ready handshake; a word accepted on the last stop
// cycle starts the next frame with no idle gap. tx_break holds the line low.
//
// Ports:
//   clk_tf          in   transmit clock
//   rst_n_tf        in   asynchronous active-low reset
//   tx_valid        in   upstream has a word on tx_data
//   tx_data         in   word to send (DATA_W bits, LSB first)
//   tx_ready        out  word accepted this cycle when tx_valid is high
//   tx_break        in   request line break (sampled only when idle)
//   transmitter_tx  out  serial line, idle high (registered)
//   tx_busy         out  frame or break in progress (registered)
//   tx_done         out  one-cycle pulse after the last stop cycle (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_tf,
  input  logic              rst_n_tf,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              tx_break,
  output logic              transmitter_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
      PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_params
    $error("uart_tx_frame: illegal parameter combination");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e          state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0]    shift_q;
  logic                 parity_q;
  logic                 bit_end;
  logic                 timer_clear;
  logic                 accept;

  // The bit timer only runs while a frame is on the line.
  assign timer_clear = (state == ST_IDLE) || (state == ST_BREAK);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_tf   (clk_tf),
    .rst_n_tf (rst_n_tf),
    .clear    (timer_clear),
    .bit_end  (bit_end)
  );

  // Ready in IDLE, or on the very last stop cycle so frames can abut.
  // Gated by reset so the handshake reads 0 while the engine is held.
  assign tx_ready = rst_n_tf && !tx_break &&
                    ((state == ST_IDLE) ||
                     (state == ST_STOP && bit_cnt == LAST_STOP && bit_end));
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk_tf or negedge rst_n_tf) begin
    if (!rst_n_tf) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      shift_q        <= '0;
      parity_q       <= 1'b0;
      transmitter_tx <= 1'b1;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      // NOTE: default-low here makes tx_done a single-cycle pulse; the STOP
      // branch overrides it only on the final stop cycle.
      tx_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tx_break) begin
            state          <= ST_BREAK;
            transmitter_tx <= 1'b0;
            tx_busy        <= 1'b1;
          end
        end

        ST_BREAK: begin
          if (!tx_break) begin
            state          <= ST_IDLE;
            transmitter_tx <= 1'b1;
            tx_busy        <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state          <= ST_DATA;
            bit_cnt        <= '0;
            transmitter_tx <= shift_q[0];
            shift_q        <= shift_q >> 1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state          <= ST_PARITY;
                transmitter_tx <= parity_q;
              end else begin
                state          <= ST_STOP;
                transmitter_tx <= 1'b1;
              end
            end else begin
              bit_cnt        <= bit_cnt + BIT_CNT_W'(1);
              transmitter_tx <= shift_q[0];
              shift_q        <= shift_q >> 1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state          <= ST_STOP;
            bit_cnt        <= '0;
            transmitter_tx <= 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              tx_done <= 1'b1;
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        default: begin
          state          <= ST_IDLE;
          transmitter_tx <= 1'b1;
          tx_busy        <= 1'b0;
        end
      endcase

      // A handshake (IDLE or last stop cycle) overrides the branch above and
      // launches the next frame; the word is captured here and never re-read.
      if (accept) begin
        state          <= ST_START;
        bit_cnt        <= '0;
        shift_q        <= tx_data;
        parity_q       <= parity_bit(DATA_W_MAX'(tx_data), 1'(PARITY_ODD));
        transmitter_tx <= 1'b0;
        tx_busy        <= 1'b1;
      end
    end
  end

endmodule
